// File: rtl/serial_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : serial_feeder
//  Purpose  : Double-buffered parallel-to-serial front end. Accepts WIDTH-bit
//             words over load/ready and streams them one bit per clock onto
//             w, gaplessly for back-to-back words. The line idles at 0.
//  Options  : SERIAL_FEEDER_LSB_FIRST_EN - when defined, words go out LSB
//             first (shift right); otherwise MSB first (shift left).
//  Revision : 1.0 - initial release
// ============================================================================
module serial_feeder #(
  parameter int WIDTH = 8
) (
  input  logic             Clock,
  input  logic             Reset,      // synchronous, active low
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             ready,
  output logic             w,
  output logic             w_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sh, sh_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] hold, hold_nxt;
  logic             hold_full, hold_full_nxt;

  logic             accept;
  logic             last_bit;
  logic             out_bit;
  logic [WIDTH-1:0] sh_shifted;

`ifdef SERIAL_FEEDER_LSB_FIRST_EN
  assign out_bit    = sh[0];
  assign sh_shifted = {1'b0, sh[WIDTH-1:1]};
`else
  assign out_bit    = sh[WIDTH-1];
  assign sh_shifted = {sh[WIDTH-2:0], 1'b0};
`endif

  // ready only looks at registers and Reset, never at load.
  assign ready     = Reset && !hold_full;
  assign accept    = load && ready;
  assign last_bit  = (cnt == LAST_BIT);

  // All outputs are forced low while Reset is held low.
  assign w_valid   = Reset && (state == SHIFT);
  assign w         = w_valid && out_bit;
  assign word_done = w_valid && last_bit;
  assign busy      = Reset && ((state == SHIFT) || hold_full);

  // State register: shifter, bit counter, holding buffer and FSM state.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state     <= IDLE;
      sh        <= '0;
      cnt       <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
    end else begin
      state     <= state_nxt;
      sh        <= sh_nxt;
      cnt       <= cnt_nxt;
      hold      <= hold_nxt;
      hold_full <= hold_full_nxt;
    end
  end

  // Next-state logic: load/bypass from IDLE, shift, park a word in hold,
  // and on the last bit reload from hold, bypass a new word, or go idle.
  always_comb begin
    state_nxt     = state;
    sh_nxt        = sh;
    cnt_nxt       = cnt;
    hold_nxt      = hold;
    hold_full_nxt = hold_full;
    case (state)
      IDLE: begin
        if (accept) begin
          sh_nxt    = data_in;
          cnt_nxt   = '0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (!last_bit) begin
          sh_nxt  = sh_shifted;
          cnt_nxt = cnt + CNT_W'(1);
          if (accept) begin
            hold_nxt      = data_in;
            hold_full_nxt = 1'b1;
          end
        end else if (hold_full) begin
          // ready is low here, so no new word can collide with the transfer.
          sh_nxt        = hold;
          hold_full_nxt = 1'b0;
          cnt_nxt       = '0;
        end else if (accept) begin
          sh_nxt  = data_in;
          cnt_nxt = '0;
        end else begin
          sh_nxt    = '0;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_feeder
//  Purpose  : Scoreboard bench for serial_feeder. Accepted words push their
//             expected bit stream into a queue; a monitor pops and compares
//             on every w_valid cycle and flags gaps and stray bits.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_feeder;

  localparam int WIDTH = 8;

  logic             Clock;
  logic             Reset;
  logic [WIDTH-1:0] data_in;
  logic             load;
  logic             ready;
  logic             w;
  logic             w_valid;
  logic             word_done;
  logic             busy;

  int checks = 0;
  int errors = 0;

  // each entry is {expected w, expected word_done}
  logic [1:0] exp_q[$];

  serial_feeder #(.WIDTH(WIDTH)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .data_in   (data_in),
    .load      (load),
    .ready     (ready),
    .w         (w),
    .w_valid   (w_valid),
    .word_done (word_done),
    .busy      (busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic [WIDTH-1:0] d);
    for (int i = 0; i < WIDTH; i++) begin
`ifdef SERIAL_FEEDER_LSB_FIRST_EN
      exp_q.push_back({d[i], (i == WIDTH - 1)});
`else
      exp_q.push_back({d[WIDTH-1-i], (i == WIDTH - 1)});
`endif
    end
  endtask

  // Offer a word with load held until accepted; report stall cycles.
  task automatic send_word(input logic [WIDTH-1:0] d, output int waits);
    bit ok;
    ok      = 1'b0;
    waits   = 0;
    data_in = d;
    load    = 1'b1;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge Clock);
      if (ready) ok = 1'b1;
      else       waits++;
    end
    if (!ok) begin
      chk("accept_timeout", 32'd0, 32'd1);
      load = 1'b0;
    end else begin
      @(posedge Clock);
      #1;
      push_word(d);
      load = 1'b0;
    end
  endtask

  // Wait for the scoreboard to empty, then confirm the line is idle.
  task automatic drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge Clock);
      t++;
    end
    if (exp_q.size() != 0) chk({name, "_drain_timeout"}, 32'd0, 32'd1);
    @(negedge Clock);
    chk({name, "_idle_w_valid"}, 32'(w_valid), 32'd0);
    chk({name, "_idle_busy"},    32'(busy),    32'd0);
    chk({name, "_idle_ready"},   32'(ready),   32'd1);
  endtask

  // Monitor: compare every payload bit, catch stray bits and stream gaps.
  always @(negedge Clock) begin
    if (Reset) begin
      if (w_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 32'(w_valid), 32'd0);
        end else begin
          chk("bit_w_done", 32'({w, word_done}), 32'(exp_q.pop_front()));
        end
        chk("busy_while_valid", 32'(busy), 32'd1);
      end else begin
        chk("idle_w", 32'({w, word_done}), 32'd0);
        if (exp_q.size() != 0) chk("stream_gap", 32'(w_valid), 32'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wt;
    logic [WIDTH-1:0] first_word;
    Reset   = 1'b0;
    load    = 1'b0;
    data_in = '0;

    // reset state
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    chk("rst_ready",   32'(ready),   32'd0);
    chk("rst_w_valid", 32'(w_valid), 32'd0);
    chk("rst_busy",    32'(busy),    32'd0);
    chk("rst_w",       32'(w),       32'd0);
    @(posedge Clock); #1;
    Reset = 1'b1;
    @(negedge Clock);
    chk("post_rst_ready", 32'(ready), 32'd1);
    chk("post_rst_busy",  32'(busy),  32'd0);

    // single word
`ifdef SERIAL_FEEDER_LSB_FIRST_EN
    first_word = 8'h0B;
`else
    first_word = 8'hD0;
`endif
    @(posedge Clock); #1;
    send_word(first_word, wt);
    chk("single_wait", 32'(wt), 32'd0);
    drain("single");

    // back-to-back: second word lands in hold, ready drops
    @(posedge Clock); #1;
    send_word(8'hA5, wt);
    send_word(8'h3C, wt);
    chk("b2b_second_wait", 32'(wt), 32'd0);
    @(negedge Clock);
    chk("b2b_ready_low", 32'(ready), 32'd0);
    chk("b2b_busy",      32'(busy),  32'd1);
    drain("b2b");

    // three words: third waits until hold empties at first word's last bit
    @(posedge Clock); #1;
    send_word(8'h96, wt);
    send_word(8'h5A, wt);
    chk("three_second_wait", 32'(wt), 32'd0);
    send_word(8'hC3, wt);
    chk("three_third_wait", 32'(wt), 32'd7);
    drain("three");

    // bypass: load offered during last bit with hold empty
    @(posedge Clock); #1;
    send_word(8'h71, wt);
    repeat (7) @(posedge Clock);
    #1;
    send_word(8'hE8, wt);
    chk("bypass_wait", 32'(wt), 32'd0);
    drain("bypass");

    // reset mid-word with a held word pending
    @(posedge Clock); #1;
    send_word(8'hFF, wt);
    send_word(8'h0F, wt);
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b0;
    @(negedge Clock);
    chk("midrst_w",       32'(w),       32'd0);
    chk("midrst_w_valid", 32'(w_valid), 32'd0);
    chk("midrst_ready",   32'(ready),   32'd0);
    chk("midrst_busy",    32'(busy),    32'd0);
    exp_q.delete();
    @(posedge Clock); #1;
    Reset = 1'b1;
    @(negedge Clock);
    chk("midrst_rel_ready", 32'(ready),   32'd1);
    chk("midrst_rel_busy",  32'(busy),    32'd0);
    chk("midrst_rel_valid", 32'(w_valid), 32'd0);
    repeat (12) @(posedge Clock);

    // a word after the mid-word reset streams normally
    #1;
    send_word(8'h4B, wt);
    drain("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_feeder.md
# serial_feeder

Parallel-to-serial front end for the sequence-detector datapath. Accepts WIDTH-bit words over a valid/ready handshake, double-buffers them, and drives one bit per Clock onto the single-bit serial line `w` that feeds the Mealy sequence detector. Back-to-back words stream with no idle cycle between them. When no word is pending, the line is held at 0.

## Interface
- WIDTH, 8: word width in bits; legal range 2–32.
- Clock  in  1  rising-edge clock; the only clock.
- Reset  in  1  synchronous, active-low reset; sampled on the rising edge of Clock.
- data_in  in  WIDTH  parallel word; sampled only on accept.
- load  in  1  word valid from upstream.
- ready  out  1  block can accept a word this cycle.
- w  out  1  serial bit to the detector.
- w_valid  out  1  `w` carries a payload bit this cycle.
- word_done  out  1  high during the cycle that carries the last bit of a word.
- busy  out  1  shifter active or holding register full.

## Operation
- Storage:
  - shift register `sh[WIDTH-1:0]`
  - bit counter `cnt` (0..WIDTH-1)
  - holding register `hold` with flag `hold_full`
  - state register: IDLE or SHIFT
- Accept rule: a word is accepted at a rising edge when `load && ready`. Accepting does not require `load` to be held on the following cycles.
- ready = Reset && !hold_full. This is combinational from registers and does not depend on `load`.
- Default bit order is MSB first: w = sh[WIDTH-1] in SHIFT; w = 0 in IDLE.
- w_valid = (state == SHIFT).
- word_done = (state == SHIFT) && (cnt == WIDTH-1).
- busy = (state == SHIFT) || hold_full.
- IDLE:
  - On accept: sh <= data_in, cnt <= 0, go to SHIFT. The word bypasses `hold`.
- SHIFT, cnt < WIDTH-1:
  - sh shifts left by one, cnt increments.
  - On accept: the word goes to `hold`, hold_full <= 1.
- SHIFT, cnt == WIDTH-1 (last bit):
  - If hold_full: sh <= hold, hold_full <= 0, cnt <= 0, stay in SHIFT.
  - Else, on accept: sh <= data_in, cnt <= 0, stay in SHIFT. This is a direct bypass.
  - Else (no pending word): go to IDLE, sh <= 0.
- Simultaneous hold-to-shifter transfer and a new load: `ready` is 0 while hold_full, so the new load is not accepted. `hold` empties at that edge and `ready` returns to 1 on the next cycle. The serial stream has no gap.
- Upstream must keep `data_in` stable while `load && !ready`. The block ignores `data_in` in that case.

## Timing
- Reset low at an edge sets state = IDLE, sh = 0, cnt = 0, hold = 0, hold_full = 0.
- Output values while Reset is low: w = 0, w_valid = 0, word_done = 0, busy = 0, ready = 0.
- Reset asserted mid-word: the word in flight and any held word are discarded. From the next cycle, w = 0 and w_valid = 0.
- Latency: a word accepted at edge k puts its first bit on `w` (w_valid = 1) in the cycle after edge k. Its last bit appears WIDTH-1 cycles later.
- Throughput: one word per WIDTH cycles, sustained, with w_valid continuously 1.
- Maximum storage is two words: one shifting and one in `hold`.
- Idle line: w = 0 between words. A gap therefore presents zeros to the detector, which returns it to its Default state and prevents a false match across a gap.

## Configuration
- Macro: SERIAL_FEEDER_LSB_FIRST_EN.
- Defined: bits go out LSB first. w = sh[0], sh shifts right, and loads are unchanged.
- Undefined (default): MSB first, as described above.
- Handshake, counts, latency and word_done timing are identical in both builds.

## Test plan
- Reset, then a single word 8'hD0 (MSB first) → w = 1,1,0,1,0,0,0,0 on 8 consecutive w_valid cycles. Downstream detector z = 1 during the 4th bit. word_done high on the 8th bit only. Then w = 0 and w_valid = 0.
- Back-to-back 8'hA5 then 8'h3C, both offered with load held → 16 consecutive w_valid cycles with w = 1010_0101_0011_1100. ready drops while hold_full and rises one cycle after the transfer. No gap.
- Three words offered continuously → the third is accepted only when hold empties at the first word's last bit. Total of 24 gapless bits, with busy high throughout.
- Reset pulled low at bit 3 of 8'hFF with 8'h0F held → the next cycle shows w = 0, w_valid = 0, ready = 0. After release: ready = 1, busy = 0, and no residual bits.
- load asserted during the last bit with hold empty → bypass to the shifter. The next word's bit 0 immediately follows the previous word's bit 7.
- SERIAL_FEEDER_LSB_FIRST_EN build: 8'h0B → w = 1,1,0,1,0,0,0,0, and the detector z = 1 on the 4th bit.
